// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with one registered output slot.
// Presents payload, one-hot grant and binary index downstream.
module rr_onehot_arbiter #(
  parameter int NR_REQ     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NR_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [NR_REQ-1:0]            out_grant,
  output logic [IDX_WIDTH-1:0]         out_index
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [IDX_WIDTH-1:0]  ptr_q;
  logic [IDX_WIDTH-1:0]  ptr_d;
  logic [IDX_WIDTH-1:0]  winner;
  logic                  found;
  logic [NR_REQ-1:0]     win_oh;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_load;
  logic                  load;
  logic                  drain;

  logic [DATA_WIDTH-1:0] data_q;
  logic [NR_REQ-1:0]     grant_q;
  logic [IDX_WIDTH-1:0]  index_q;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin : scan_p
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (i == int'(winner))
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ptr_d = (winner == IDX_WIDTH'(NR_REQ-1))
               ? '0 : winner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Ready is held low during reset so nothing is accepted then lost.
  always_comb begin
    out_valid = (state_q == FULL);
    can_load  = (state_q == EMPTY) || out_ready;
    req_ready = (can_load && found && !rst) ? win_oh : '0;
    load      = |req_ready;
    drain     = (state_q == FULL) && out_ready && !load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      index_q <= '0;
    end else if (load) begin
      ptr_q   <= ptr_d;
      data_q  <= sel_data;
      grant_q <= win_oh;
      index_q <= winner;
    end else if (drain) begin
      grant_q <= '0;
    end
  end

  assign out_data  = data_q;
  assign out_grant = grant_q;
  assign out_index = index_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed table + corner sequences + random scoreboard
// for rr_onehot_arbiter.
module tb_rr_onehot_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_grant;
  logic [1:0]    out_index;

  int n_tests = 0;
  int n_fail  = 0;

  rr_onehot_arbiter #(.NR_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_grant(out_grant),
    .out_index(out_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic        ordy;
    logic [3:0]  rr;
    logic        ov;
    logic [3:0]  og;
    logic [1:0]  oi;
    logic [31:0] od;
  } vec_t;

  vec_t vt[18];

  task automatic chk(string nm, int id,
                     logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, id, act, exp);
    end
  endtask

  logic [3:0]  mv;
  logic [3:0]  rr;
  logic        ev;
  logic [3:0]  eg;
  logic        po;
  logic [31:0] exp_d;
  int          w;
  int          seq[N];
  int          waitc[N];

  initial begin
    vt[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 32'h0002};
    vt[1]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 32'h0103};
    vt[2]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 32'h0200};
    vt[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h0301};
    vt[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 32'h0402};
    vt[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 32'h0503};
    vt[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 32'h0600};
    vt[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h0701};
    for (int s = 8; s < 13; s++)
      vt[s] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 32'h0701};
    vt[13] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 32'h0D02};
    vt[14] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 32'h0E01};
    vt[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 32'h0E01};
    vt[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 32'h0E01};
    vt[17] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 32'h1100};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 0, 32'(out_valid), 0);
    chk("rst_grant", 0, 32'(out_grant), 0);
    chk("rst_data",  0, out_data, 0);
    chk("rst_index", 0, 32'(out_index), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      req_valid = vt[s].rv;
      out_ready = vt[s].ordy;
      for (int i = 0; i < N; i++)
        req_data[i*DW +: DW] = 32'((s << 8) | i);
      #1;
      chk("vec_ready", s, 32'(req_ready), 32'(vt[s].rr));
      @(posedge clk);
      #1;
      chk("vec_valid", s, 32'(out_valid), 32'(vt[s].ov));
      chk("vec_grant", s, 32'(out_grant), 32'(vt[s].og));
      chk("vec_index", s, 32'(out_index), 32'(vt[s].oi));
      chk("vec_data",  s, out_data, vt[s].od);
    end

    // Mid-cycle async reset while FULL with 0xDEAD.
    @(negedge clk);
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[31:0] = 32'hDEAD;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_setup", 0, out_data, 32'hDEAD);
    #1;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("mid_valid", 0, 32'(out_valid), 0);
    chk("mid_grant", 0, 32'(out_grant), 0);
    chk("mid_data",  0, out_data, 0);
    chk("mid_index", 0, 32'(out_index), 0);
    chk("mid_ready", 0, 32'(req_ready), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 0, 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_grant", 0, 32'(out_grant), 32'b0001);

    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    #1;
    rst = 1'b0;
    mv  = '0;
    ev  = 1'b0;
    eg  = '0;
    for (int i = 0; i < N; i++) begin
      seq[i]   = 0;
      waitc[i] = 0;
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!mv[i] && $urandom_range(1, 0) == 1) mv[i] = 1'b1;
      req_valid = mv;
      for (int i = 0; i < N; i++)
        req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
      out_ready = ($urandom_range(3, 0) != 0);
      po = out_ready;
      #1;
      rr = req_ready;
      chk("rnd_onehot", c,
          32'($countones(rr) <= 1 && (rr & ~mv) == 0), 1);
      chk("rnd_ready", c, 32'(rr != 0),
          32'((!ev || po) && mv != 0));
      w = 0;
      for (int i = 0; i < N; i++) if (rr[i]) w = i;
      exp_d = {8'(w), 24'(seq[w])};
      if (rr != 0) begin
        for (int i = 0; i < N; i++) begin
          if (mv[i] && i != w) begin
            waitc[i]++;
            chk("rnd_starve", i, 32'(waitc[i] <= N-1), 1);
          end
        end
        waitc[w] = 0;
      end
      @(posedge clk);
      #1;
      if (rr != 0) begin
        ev = 1'b1;
        eg = rr;
        chk("rnd_index", c, 32'(out_index), 32'(w));
        chk("rnd_data",  c, out_data, exp_d);
        seq[w]++;
        mv[w] = 1'b0;
      end else if (ev && po) begin
        ev = 1'b0;
        eg = '0;
      end
      chk("rnd_valid", c, 32'(out_valid), 32'(ev));
      chk("rnd_grant", c, 32'(out_grant), 32'(eg));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
